tff_bank: RTL

//  Parametrised bank of WIDTH T flip-flops; next-generation replacement for the single-bit TFF.
//  Two modes:
//    - mode 0: independent per-channel toggle.
//    - mode 1: channels cascade into a synchronous T-FF up/down counter with terminal count.

---
 rtl/tff_bank_if.sv | 26 ++
 rtl/tff_bank.sv | 95 +++++++++
 2 files changed

// File: rtl/tff_bank_if.sv
// tff_bank_if: control/data bundle for the tff_bank T flip-flop bank.
// The master drives the controls (en, mode, dir, load, d, t) and observes q, tc, ovf.
// The slave is the bank itself.
interface tff_bank_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output en, mode, dir, load, d, t,
        input  q, tc, ovf
    );

    modport slave (
        input  en, mode, dir, load, d, t,
        output q, tc, ovf
    );
endinterface : tff_bank_if

// File: rtl/tff_bank.sv
// tff_bank: parametrised bank of WIDTH T flip-flops.
//   mode 0: each channel toggles independently on its own t[i].
//   mode 1: the channels form a synchronous up/down T-FF counter. t[0] is the count enable.
//           tc flags the terminal count, and the sticky ovf flag records a wrap.
// Optional build macro TFF_BANK_SAT_EN: the mode-1 counter saturates at the
// terminal value instead of wrapping. ovf still sets when this happens.
// Reset is synchronous and active-high.
// Priority on each edge is rst > load > en.
module tff_bank #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic        clk,
    input  logic        rst,
    tff_bank_if.slave   bus
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] tt_s;
    logic             tc_s;

    // Cascade toggle chain: bit i toggles only when every lower bit is at the carry/borrow value.
    always_comb begin
        tt_s    = {WIDTH{1'b0}};
        tt_s[0] = bus.t[0];
        for (int i = 1; i < WIDTH; i++) begin
            if (bus.dir) begin
                tt_s[i] = tt_s[i-1] & q_q[i-1];
            end else begin
                tt_s[i] = tt_s[i-1] & ~q_q[i-1];
            end
        end
    end

    // Terminal count: the counter is enabled and sits at all-ones (up) or zero (down).
    always_comb begin
        if (bus.dir) begin
            tc_s = bus.mode & bus.en & bus.t[0] & (&q_q);
        end else begin
            tc_s = bus.mode & bus.en & bus.t[0] & ~(|q_q);
        end
    end

    // Next-state selection for q and ovf. rst is applied in the register, so load has the next priority.
    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (bus.load) begin
            q_d   = bus.d;
            ovf_d = 1'b0;
        end else if (bus.en) begin
            if (bus.mode) begin
`ifdef TFF_BANK_SAT_EN
                if (tc_s) begin
                    q_d = q_q;
                end else begin
                    q_d = q_q ^ tt_s;
                end
`else
                q_d = q_q ^ tt_s;
`endif
                if (tc_s) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end else begin
                q_d   = q_q ^ bus.t;
                ovf_d = ovf_q;
            end
        end else begin
            q_d   = q_q;
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= RST_VAL;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q   = q_q;
    assign bus.tc  = tc_s;
    assign bus.ovf = ovf_q;

endmodule : tff_bank
